scalar_mult_ctrl: RTL and testbench

Sequencer that computes Q = k·P on Ed25519 extended twisted Edwards coordinates (X, Y, Z, T) by driving a single PointAdd instance through an MSB-first, constant-time double-and-add loop. It sits between the signature/key-generation top level and PointAdd. It owns PointAdd's start strobe, its doubling select and all eight operand buses, and it holds the running accumulator between operations.

---
 rtl/scalar_mult_ctrl.sv | 178 +++++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// Double-and-add sequencer for Ed25519 scalar multiplication Q = k*P.
// Drives one external PointAdd unit; holds accumulator, base point and scalar.
module scalar_mult_ctrl #(
    parameter int unsigned N_BITS = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_scalar,
    input  logic [255:0]      i_px,
    input  logic [255:0]      i_py,
    input  logic [255:0]      i_pz,
    input  logic [255:0]      i_pt,
    output logic              o_busy,
    output logic              o_finished,
    output logic [255:0]      o_qx,
    output logic [255:0]      o_qy,
    output logic [255:0]      o_qz,
    output logic [255:0]      o_qt,
    output logic              o_pa_start,
    output logic              o_pa_doubling,
    output logic [255:0]      o_pa_x1,
    output logic [255:0]      o_pa_y1,
    output logic [255:0]      o_pa_z1,
    output logic [255:0]      o_pa_t1,
    output logic [255:0]      o_pa_x2,
    output logic [255:0]      o_pa_y2,
    output logic [255:0]      o_pa_z2,
    output logic [255:0]      o_pa_t2,
    input  logic [255:0]      i_pa_x3,
    input  logic [255:0]      i_pa_y3,
    input  logic [255:0]      i_pa_z3,
    input  logic [255:0]      i_pa_t3,
    input  logic              i_pa_finished
);

    localparam int unsigned CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    // Point words packed as [3]=T, [2]=Z, [1]=Y, [0]=X.
    localparam logic [3:0][255:0] IDENT = {256'd0, 256'd1, 256'd1, 256'd0};

    typedef enum logic [2:0] {
        IDLE,
        DBL_ISSUE,
        DBL_WAIT,
        ADD_ISSUE,
        ADD_WAIT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0][255:0] r, r_nxt;
    logic [3:0][255:0] p;
    logic [3:0][255:0] op1, op2;
    logic [3:0][255:0] q;
    logic [3:0][255:0] pa_res;
    logic [N_BITS-1:0] s, s_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              dbl;
    logic              load_p;
    logic              issue;
    logic              issue_dbl;
    logic              load_q;

    assign pa_res = {i_pa_t3, i_pa_z3, i_pa_y3, i_pa_x3};

    always_comb begin
        state_nxt  = state;
        r_nxt      = r;
        s_nxt      = s;
        cnt_nxt    = cnt;
        load_p     = 1'b0;
        issue      = 1'b0;
        issue_dbl  = 1'b0;
        load_q     = 1'b0;
        o_busy     = (state != IDLE);
        o_finished = 1'b0;
        o_pa_start = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    load_p    = 1'b1;
                    s_nxt     = i_scalar;
                    r_nxt     = IDENT;
                    cnt_nxt   = CW'(N_BITS - 1);
                    issue     = 1'b1;
                    issue_dbl = 1'b1;
                    state_nxt = DBL_ISSUE;
                end
            end
            DBL_ISSUE: begin
                o_pa_start = 1'b1;
                state_nxt  = DBL_WAIT;
            end
            DBL_WAIT: begin
                if (i_pa_finished) begin
                    r_nxt     = pa_res;
                    issue     = 1'b1;
                    state_nxt = ADD_ISSUE;
                end
            end
            ADD_ISSUE: begin
                o_pa_start = 1'b1;
                state_nxt  = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (i_pa_finished) begin
                    if (s[N_BITS-1]) begin
                        r_nxt = pa_res;
                    end
                    s_nxt = s << 1;
                    if (cnt == '0) begin
                        load_q    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt - 1'b1;
                        issue     = 1'b1;
                        issue_dbl = 1'b1;
                        state_nxt = DBL_ISSUE;
                    end
                end
            end
            DONE: begin
                o_finished = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands and Q are loaded on the edge entering ISSUE/DONE from the
    // next-R value, so they are already valid during that cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
            r     <= IDENT;
            p     <= '0;
            s     <= '0;
            cnt   <= '0;
            op1   <= '0;
            op2   <= '0;
            dbl   <= 1'b0;
            q     <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
            if (load_p) begin
                p <= {i_pt, i_pz, i_py, i_px};
            end
            if (issue) begin
                op1 <= r_nxt;
                op2 <= issue_dbl ? r_nxt : p;
                dbl <= issue_dbl;
            end
            if (load_q) begin
                q <= r_nxt;
            end
        end
    end

    assign o_pa_doubling = dbl;
    assign o_pa_x1 = op1[0];
    assign o_pa_y1 = op1[1];
    assign o_pa_z1 = op1[2];
    assign o_pa_t1 = op1[3];
    assign o_pa_x2 = op2[0];
    assign o_pa_y2 = op2[1];
    assign o_pa_z2 = op2[2];
    assign o_pa_t2 = op2[3];
    assign o_qx    = q[0];
    assign o_qy    = q[1];
    assign o_qz    = q[2];
    assign o_qt    = q[3];

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl with N_BITS=4 and a stub PointAdd (D=3) that
// returns operand 1 + 1 in every word; expected values are hand tables.
module tb_scalar_mult_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned D  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NB-1:0] scalar;
    logic [255:0]  px, py, pz, pt;
    logic          busy, finished;
    logic [255:0]  qx, qy, qz, qt;
    logic          pa_start, pa_dbl;
    logic [255:0]  x1, y1, z1, t1, x2, y2, z2, t2;
    logic [255:0]  x3, y3, z3, t3;
    logic          pa_fin;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    scalar_mult_ctrl #(.N_BITS(NB)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_scalar(scalar),
        .i_px(px), .i_py(py), .i_pz(pz), .i_pt(pt),
        .o_busy(busy), .o_finished(finished),
        .o_qx(qx), .o_qy(qy), .o_qz(qz), .o_qt(qt),
        .o_pa_start(pa_start), .o_pa_doubling(pa_dbl),
        .o_pa_x1(x1), .o_pa_y1(y1), .o_pa_z1(z1), .o_pa_t1(t1),
        .o_pa_x2(x2), .o_pa_y2(y2), .o_pa_z2(z2), .o_pa_t2(t2),
        .i_pa_x3(x3), .i_pa_y3(y3), .i_pa_z3(z3), .i_pa_t3(t3),
        .i_pa_finished(pa_fin)
    );

    // Stub PointAdd: finished is high D cycles after the start cycle.
    int unsigned pend;
    logic        active;
    always @(posedge clk) begin
        if (!rst) begin
            pend   <= 0;
            active <= 1'b0;
            pa_fin <= 1'b0;
            x3 <= '0; y3 <= '0; z3 <= '0; t3 <= '0;
        end else begin
            pa_fin <= 1'b0;
            if (pa_start) begin
                pend   <= D - 1;
                active <= 1'b1;
                x3 <= x1 + 1; y3 <= y1 + 1; z3 <= z1 + 1; t3 <= t1 + 1;
            end else if (active) begin
                if (pend == 1) begin
                    pa_fin <= 1'b1;
                    active <= 1'b0;
                end
                pend <= pend - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fin"}, finished, 0);
        check({tag, "_start"}, pa_start, 0);
        check({tag, "_dbl"}, pa_dbl, 0);
        check({tag, "_x1"}, x1, 0);
        check({tag, "_y1"}, y1, 0);
        check({tag, "_x2"}, x2, 0);
        check({tag, "_t2"}, t2, 0);
        check({tag, "_qx"}, qx, 0);
        check({tag, "_qy"}, qy, 0);
        check({tag, "_qz"}, qz, 0);
        check({tag, "_qt"}, qt, 0);
    endtask

    // Called at a negedge; the start is accepted on the following posedge.
    task automatic launch(input logic [NB-1:0] k, input logic [255:0] base);
        start  = 1'b1;
        scalar = k;
        px = base; py = base + 1; pz = base + 2; pt = base + 3;
    endtask

    // tab byte i = expected operand-1 X word of operation i.
    // Returns after sampling cycle 33 (the DONE cycle).
    task automatic observe(input logic [63:0] tab, input logic [255:0] base,
                           input logic [255:0] q_exp, input logic [255:0] q_prev,
                           input int inj_a, input int inj_b);
        logic [255:0] ex1;
        logic         edbl;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("q_held", qx, q_prev);
            end
            if (c <= 32) begin
                ex1  = 256'(tab[8*((c-1)/4) +: 8]);
                edbl = (((c - 1) / 4) % 2) == 0;
                check("pa_start", pa_start, ((c - 1) % 4) == 0);
                check("busy", busy, 1);
                check("finished", finished, 0);
                check("doubling", pa_dbl, edbl);
                check("x1", x1, ex1);
                check("y1", y1, ex1 + 1);
                check("z1", z1, ex1 + 1);
                check("t1", t1, ex1);
                check("x2", x2, edbl ? ex1 : base);
                check("t2", t2, edbl ? ex1 : base + 3);
            end else begin
                check("done_start", pa_start, 0);
                check("done_busy", busy, 1);
                check("done_fin", finished, 1);
                check("qx", qx, q_exp);
                check("qy", qy, q_exp + 1);
                check("qz", qz, q_exp + 1);
                check("qt", qt, q_exp);
            end
            start = (c == inj_a) || (c == inj_b);
            if (start) begin
                scalar = 4'b0101;
                px = 256'hdead; py = 256'hbeef; pz = 256'hcafe; pt = 256'hf00d;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; scalar = '0;
        px = '0; py = '0; pz = '0; pt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_start", pa_start, 0);

        // k=1010: adds committed on iterations 0 and 2 only.
        launch(4'b1010, 256'h100);
        observe(64'h06_05_04_03_03_02_01_00, 256'h100, 256'd6, 256'd0, 0, 0);
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_fin", finished, 0);
        check("post_q", qx, 6);

        // Starts while busy at cycles 2 and 20 with garbage inputs: no effect.
        launch(4'b1010, 256'h200);
        observe(64'h06_05_04_03_03_02_01_00, 256'h200, 256'd6, 256'd6, 2, 20);
        @(negedge clk);
        check("inj_busy", busy, 0);

        // One-cycle reset sampled at the end of cycle 6 (ADD_WAIT).
        launch(4'b1010, 256'h300);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_idle_busy", busy, 0);
            check("rst_idle_start", pa_start, 0);
        end

        // Fresh job after reset.
        launch(4'b0111, 256'h400);
        observe(64'h06_05_04_03_02_01_01_00, 256'h400, 256'd7, 256'd0, 0, 0);

        // Back-to-back: start in DONE is ignored, start one cycle later accepted.
        launch(4'b1111, 256'h600);
        @(negedge clk);
        check("b2b_busy", busy, 0);
        check("b2b_start", pa_start, 0);
        check("b2b_q", qx, 7);
        observe(64'h07_06_05_04_03_02_01_00, 256'h600, 256'd8, 256'd7, 0, 0);
        @(negedge clk);

        // k=0: every add discarded, result is identity after four doublings.
        launch(4'b0000, 256'h700);
        observe(64'h04_03_03_02_02_01_01_00, 256'h700, 256'd4, 256'd8, 0, 0);
        @(negedge clk);
        check("end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
